// File: rtl/lgn_pkg.sv
// Shared constants and state encoding for the logic-gate-network classifier and its UART host.
package lgn_pkg;

    localparam int INPUT_BITS     = 400;
    localparam int CLASSES        = 10;
    localparam int BITS_PER_VALUE = 7;

    localparam int INPUT_BYTES = INPUT_BITS / 8;
    localparam int OUTPUT_BITS = CLASSES * BITS_PER_VALUE;
    localparam int CLASS_IDX_W = (CLASSES > 1) ? $clog2(CLASSES) : 1;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SEND    = 3'd1,
        ST_WAIT_TX = 3'd2,
        ST_RECV    = 3'd3,
        ST_DONE    = 3'd4
    } lgn_state_e;

endpackage

// File: rtl/lgn_argmax_acc.sv
// Running argmax over a stream of class scores; ties keep the lowest index.
module lgn_argmax_acc
    import lgn_pkg::*;
#(
    parameter int BITS_PER_VALUE = lgn_pkg::BITS_PER_VALUE,
    parameter int IDX_W          = lgn_pkg::CLASS_IDX_W
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      clr,
    input  logic                      upd,
    input  logic [IDX_W-1:0]          idx,
    input  logic [BITS_PER_VALUE-1:0] value,
    output logic [IDX_W-1:0]          best_class,
    output logic [BITS_PER_VALUE-1:0] best_score
);

    logic [IDX_W-1:0]          best_class_q, best_class_d;
    logic [BITS_PER_VALUE-1:0] best_score_q, best_score_d;

    // Slot 0 always seeds the accumulator so stale values from a prior run never win.
    always_comb begin
        best_class_d = best_class_q;
        best_score_d = best_score_q;
        if (clr) begin
            best_class_d = {IDX_W{1'b0}};
            best_score_d = {BITS_PER_VALUE{1'b0}};
        end else if (upd && ((idx == {IDX_W{1'b0}}) || (value > best_score_q))) begin
            best_class_d = idx;
            best_score_d = value;
        end else begin
            best_class_d = best_class_q;
            best_score_d = best_score_q;
        end
    end

    // Best-so-far registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            best_class_q <= {IDX_W{1'b0}};
            best_score_q <= {BITS_PER_VALUE{1'b0}};
        end else begin
            best_class_q <= best_class_d;
            best_score_q <= best_score_d;
        end
    end

    assign best_class = best_class_q;
    assign best_score = best_score_q;

endmodule

// File: rtl/lgn_uart_host.sv
// UART host for the classifier: streams one frame out byte by byte, then gathers and ranks the scores.
module lgn_uart_host
    import lgn_pkg::*;
#(
    parameter int INPUT_BITS     = lgn_pkg::INPUT_BITS,
    parameter int CLASSES        = lgn_pkg::CLASSES,
    parameter int BITS_PER_VALUE = lgn_pkg::BITS_PER_VALUE,
    parameter int TIMEOUT_CYCLES = 1000000,
    localparam int IDX_W = (CLASSES > 1) ? $clog2(CLASSES) : 1,
    localparam int OUT_W = CLASSES * BITS_PER_VALUE
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic [INPUT_BITS-1:0]     frame,
    output logic                      busy,
    output logic                      done,
    output logic                      timeout,
    output logic                      pad_err,
    output logic [OUT_W-1:0]          scores,
    output logic [IDX_W-1:0]          best_class,
    output logic [BITS_PER_VALUE-1:0] best_score,
    output logic [7:0]                tx_byte,
    output logic                      tx_dv,
    input  logic                      tx_active,
    input  logic                      tx_done,
    input  logic [7:0]                rx_byte,
    input  logic                      rx_dv
);

    localparam int NBYTES = INPUT_BITS / 8;
    localparam int BC_W   = $clog2(NBYTES + 1);
    localparam int TMO_W  = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [BC_W-1:0]  LAST_BYTE  = BC_W'(NBYTES - 1);
    localparam logic [IDX_W-1:0] LAST_CLASS = IDX_W'(CLASSES - 1);
    localparam logic [TMO_W-1:0] TMO_LAST   = TMO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [7:0]       PAD_MASK   = 8'(~((16'd1 << BITS_PER_VALUE) - 16'd1));

    lgn_state_e              state_q, state_d;
    logic [INPUT_BITS-1:0]   frame_q, frame_d;
    logic [BC_W-1:0]         byte_cnt_q, byte_cnt_d;
    logic [IDX_W-1:0]        class_cnt_q, class_cnt_d;
    logic [TMO_W-1:0]        tmo_cnt_q, tmo_cnt_d;
    logic [OUT_W-1:0]        scores_q, scores_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;
    logic                    timeout_q, timeout_d;
    logic                    pad_err_q, pad_err_d;
    logic [7:0]              tx_byte_q, tx_byte_d;
    logic                    tx_dv_q, tx_dv_d;
    logic                    acc_clr_s, acc_upd_s;
    logic [BITS_PER_VALUE-1:0] rx_val_s;

    assign rx_val_s = rx_byte[BITS_PER_VALUE-1:0];

    // Protocol sequencer: next state, datapath updates and strobes.
    always_comb begin
        state_d     = state_q;
        frame_d     = frame_q;
        byte_cnt_d  = byte_cnt_q;
        class_cnt_d = class_cnt_q;
        tmo_cnt_d   = tmo_cnt_q;
        scores_d    = scores_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        timeout_d   = timeout_q;
        pad_err_d   = pad_err_q;
        tx_byte_d   = tx_byte_q;
        tx_dv_d     = 1'b0;
        acc_clr_s   = 1'b0;
        acc_upd_s   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    frame_d    = frame;
                    byte_cnt_d = {BC_W{1'b0}};
                    scores_d   = {OUT_W{1'b0}};
                    pad_err_d  = 1'b0;
                    timeout_d  = 1'b0;
                    busy_d     = 1'b1;
                    acc_clr_s  = 1'b1;
                    state_d    = ST_SEND;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SEND: begin
                if (!tx_active) begin
                    tx_byte_d  = frame_q[7:0];
                    tx_dv_d    = 1'b1;
                    frame_d    = frame_q >> 4'd8;
                    byte_cnt_d = byte_cnt_q + BC_W'(1);
                    // The final byte's completion is irrelevant: the responder only answers after it.
                    if (byte_cnt_q == LAST_BYTE) begin
                        class_cnt_d = {IDX_W{1'b0}};
                        tmo_cnt_d   = {TMO_W{1'b0}};
                        state_d     = ST_RECV;
                    end else begin
                        state_d = ST_WAIT_TX;
                    end
                end else begin
                    state_d = ST_SEND;
                end
            end
            ST_WAIT_TX: begin
                if (tx_done) begin
                    state_d = ST_SEND;
                end else begin
                    state_d = ST_WAIT_TX;
                end
            end
            ST_RECV: begin
                if (rx_dv) begin
                    acc_upd_s = 1'b1;
                    tmo_cnt_d = {TMO_W{1'b0}};
                    for (int c = 0; c < CLASSES; c++) begin
                        scores_d[c*BITS_PER_VALUE +: BITS_PER_VALUE] =
                            (class_cnt_q == IDX_W'(c)) ? rx_val_s
                                                       : scores_q[c*BITS_PER_VALUE +: BITS_PER_VALUE];
                    end
                    if ((rx_byte & PAD_MASK) != 8'h00) begin
                        pad_err_d = 1'b1;
                    end else begin
                        pad_err_d = pad_err_q;
                    end
                    if (class_cnt_q == LAST_CLASS) begin
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                        state_d = ST_DONE;
                    end else begin
                        class_cnt_d = class_cnt_q + IDX_W'(1);
                    end
                end else if (tmo_cnt_q == TMO_LAST) begin
                    timeout_d = 1'b1;
                    done_d    = 1'b1;
                    busy_d    = 1'b0;
                    state_d   = ST_DONE;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            frame_q     <= {INPUT_BITS{1'b0}};
            byte_cnt_q  <= {BC_W{1'b0}};
            class_cnt_q <= {IDX_W{1'b0}};
            tmo_cnt_q   <= {TMO_W{1'b0}};
            scores_q    <= {OUT_W{1'b0}};
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            timeout_q   <= 1'b0;
            pad_err_q   <= 1'b0;
            tx_byte_q   <= 8'h00;
            tx_dv_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            frame_q     <= frame_d;
            byte_cnt_q  <= byte_cnt_d;
            class_cnt_q <= class_cnt_d;
            tmo_cnt_q   <= tmo_cnt_d;
            scores_q    <= scores_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            timeout_q   <= timeout_d;
            pad_err_q   <= pad_err_d;
            tx_byte_q   <= tx_byte_d;
            tx_dv_q     <= tx_dv_d;
        end
    end

    lgn_argmax_acc #(
        .BITS_PER_VALUE (BITS_PER_VALUE),
        .IDX_W          (IDX_W)
    ) u_argmax (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr        (acc_clr_s),
        .upd        (acc_upd_s),
        .idx        (class_cnt_q),
        .value      (rx_val_s),
        .best_class (best_class),
        .best_score (best_score)
    );

    assign busy    = busy_q;
    assign done    = done_q;
    assign timeout = timeout_q;
    assign pad_err = pad_err_q;
    assign scores  = scores_q;
    assign tx_byte = tx_byte_q;
    assign tx_dv   = tx_dv_q;

endmodule

// File: tb/tb_lgn_uart_host.sv
// Directed bench for lgn_uart_host with a simple transmitter handshake and scripted responder.
`timescale 1ns/1ps
module tb_lgn_uart_host;

    localparam int NB = 50;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [399:0] frame = '0;
    logic        busy, done, timeout, pad_err;
    logic [69:0] scores;
    logic [3:0]  best_class;
    logic [6:0]  best_score;
    logic [7:0]  tx_byte;
    logic        tx_dv;
    logic        tx_active = 1'b0;
    logic        tx_done = 1'b0;
    logic [7:0]  rx_byte = 8'h00;
    logic        rx_dv = 1'b0;

    int n_checks = 0;
    int n_errors = 0;
    int tx_dv_total = 0;
    int done_total = 0;
    int hold_dv;
    logic [7:0] tx_log [0:NB-1];
    logic [7:0] resp [0:9];

    lgn_uart_host #(.TIMEOUT_CYCLES(1000)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .frame(frame),
        .busy(busy), .done(done), .timeout(timeout), .pad_err(pad_err),
        .scores(scores), .best_class(best_class), .best_score(best_score),
        .tx_byte(tx_byte), .tx_dv(tx_dv), .tx_active(tx_active), .tx_done(tx_done),
        .rx_byte(rx_byte), .rx_dv(rx_dv)
    );

    always #5 clk = ~clk;

    // Pulse counters for strobe outputs.
    always @(posedge clk) begin
        if (tx_dv) tx_dv_total <= tx_dv_total + 1;
        if (done)  done_total  <= done_total + 1;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [399:0] make_frame(input logic [7:0] add, input logic [7:0] xr);
        logic [399:0] f;
        f = '0;
        for (int k = 0; k < NB; k++) f[8*k +: 8] = (8'(k) + add) ^ xr;
        return f;
    endfunction

    task automatic set_resp(input logic [79:0] v);
        for (int i = 0; i < 10; i++) resp[i] = v[79-8*i -: 8];
    endtask

    // Expected score vector for the first n response slots, rest zero.
    function automatic logic [69:0] exp_scores(input int n);
        logic [69:0] s;
        s = '0;
        for (int c = 0; c < n; c++) s[7*c +: 7] = resp[c][6:0];
        return s;
    endfunction

    // Emulates the transmitter for a whole frame; optional long busy hold and stray rx_dv.
    task automatic tx_serve(input int hold_idx, input int stray_idx);
        int w;
        hold_dv = 0;
        for (int k = 0; k < NB; k++) begin
            w = 0;
            while (!tx_dv && w < 600) begin
                step();
                w++;
            end
            if (!tx_dv) begin
                check("tx_dv_wait", {127'd0, tx_dv}, 128'd1);
                return;
            end
            tx_log[k] = tx_byte;
            tx_active = 1'b1;
            if (k == stray_idx) begin
                rx_byte = 8'h55;
                rx_dv   = 1'b1;
            end
            step();
            rx_dv = 1'b0;
            rx_byte = 8'h00;
            step();
            step();
            if (k == hold_idx) begin
                tx_done = 1'b1;
                step();
                tx_done = 1'b0;
                for (int i = 0; i < 200; i++) begin
                    if (tx_dv) hold_dv++;
                    if (i == 50) begin
                        frame = make_frame(8'h11, 8'h00);
                        start = 1'b1;
                    end
                    if (i == 51) start = 1'b0;
                    step();
                end
                start = 1'b0;
                tx_active = 1'b0;
            end else begin
                tx_active = 1'b0;
                tx_done = 1'b1;
                step();
                tx_done = 1'b0;
            end
        end
    endtask

    task automatic check_tx(input string tag, input logic [7:0] add, input logic [7:0] xr);
        int bad;
        bad = 0;
        for (int k = 0; k < NB; k++) if (tx_log[k] !== ((8'(k) + add) ^ xr)) bad++;
        check(tag, 128'(bad), 128'd0);
    endtask

    task automatic respond(input int n);
        for (int i = 0; i < n; i++) begin
            rx_byte = resp[i];
            rx_dv = 1'b1;
            step();
            rx_dv = 1'b0;
            rx_byte = 8'h00;
            if (i < n - 1) begin
                step();
                step();
            end
        end
    endtask

    task automatic wait_done(output int cyc);
        cyc = 0;
        while (!done && cyc < 3000) begin
            step();
            cyc++;
        end
        if (!done) check("done_wait", {127'd0, done}, 128'd1);
    endtask

    task automatic do_start(input logic [399:0] f);
        frame = f;
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    // Full run with prompt responder; checks results against hand-computed argmax.
    task automatic full_run(input string tag, input logic [3:0] eb_cls, input logic [6:0] eb_sc,
                            input logic e_pad);
        int cyc, d0;
        d0 = done_total;
        do_start(make_frame(8'd1, 8'd0));
        tx_serve(-1, -1);
        repeat (4) step();
        respond(10);
        wait_done(cyc);
        step();
        step();
        check({tag, "_scores"}, 128'(scores), 128'(exp_scores(10)));
        check({tag, "_best_class"}, 128'(best_class), 128'(eb_cls));
        check({tag, "_best_score"}, 128'(best_score), 128'(eb_sc));
        check({tag, "_pad_err"}, 128'(pad_err), 128'(e_pad));
        check({tag, "_timeout"}, 128'(timeout), 128'd0);
        check({tag, "_done_once"}, 128'(done_total - d0), 128'd1);
        check({tag, "_busy_low"}, 128'(busy), 128'd0);
    endtask

    initial begin
        int cyc, dv0, d0;

        // Reset state
        repeat (3) step();
        check("rst_outputs", {busy, done, timeout, pad_err, tx_dv, tx_byte}, 128'd0);
        check("rst_scores", 128'(scores), 128'd0);
        check("rst_best", {best_class, best_score}, 128'd0);
        rst_n = 1'b1;
        step();

        // Test 1: byte-k = k+1 frame, ties resolved to lowest index
        set_resp({8'd5, 8'd9, 8'd3, 8'd9, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd1});
        dv0 = tx_dv_total;
        d0 = done_total;
        do_start(make_frame(8'd1, 8'd0));
        check("t1_busy_after_start", 128'(busy), 128'd1);
        tx_serve(-1, -1);
        step();
        check_tx("t1_tx_order", 8'd1, 8'd0);
        check("t1_tx_dv_count", 128'(tx_dv_total - dv0), 128'd50);
        repeat (3) step();
        respond(10);
        wait_done(cyc);
        step();
        step();
        check("t1_scores", 128'(scores), 128'(exp_scores(10)));
        check("t1_best_class", 128'(best_class), 128'd1);
        check("t1_best_score", 128'(best_score), 128'd9);
        check("t1_pad_timeout", {pad_err, timeout}, 128'd0);
        check("t1_done_once", 128'(done_total - d0), 128'd1);

        // Test 2: all zero
        set_resp(80'd0);
        full_run("t2", 4'd0, 7'd0, 1'b0);

        // Test 3: maximum in the last slot
        set_resp({8'd10, 8'd20, 8'd30, 8'd40, 8'd50, 8'd60, 8'd70, 8'd80, 8'd90, 8'h7F});
        full_run("t3", 4'd9, 7'd127, 1'b0);

        // Test 4: pad bit set in slot 2
        set_resp({8'd1, 8'd2, 8'h85, 8'd4, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0});
        full_run("t4", 4'd2, 7'd5, 1'b1);
        check("t4_slot2", 128'(scores[14 +: 7]), 128'd5);

        // Test 5: responder stops after 4 bytes; stray rx_dv during transmit
        set_resp({8'd7, 8'd3, 8'd8, 8'd2, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0});
        d0 = done_total;
        do_start(make_frame(8'd1, 8'd0));
        check("t5_flags_cleared", {pad_err, timeout}, 128'd0);
        tx_serve(-1, 10);
        repeat (4) step();
        respond(3);
        step();
        step();
        rx_byte = resp[3];
        rx_dv = 1'b1;
        step();
        rx_dv = 1'b0;
        rx_byte = 8'h00;
        wait_done(cyc);
        check("t5_timeout_latency", 128'(cyc), 128'd1000);
        check("t5_timeout_flag", 128'(timeout), 128'd1);
        step();
        step();
        check("t5_scores_partial", 128'(scores), 128'(exp_scores(4)));
        check("t5_best", {best_class, best_score}, {4'd2, 7'd8});
        check("t5_timeout_held", {timeout, busy}, 128'd2);
        check("t5_done_once", 128'(done_total - d0), 128'd1);

        // Test 6: transmitter backpressure, start while busy, reset during receive
        set_resp({8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8, 8'd9, 8'd10});
        dv0 = tx_dv_total;
        do_start(make_frame(8'd0, 8'hA0));
        tx_serve(20, -1);
        step();
        check("t6_no_dv_while_active", 128'(hold_dv), 128'd0);
        check_tx("t6_tx_bytes_start_ignored", 8'd0, 8'hA0);
        check("t6_tx_dv_count", 128'(tx_dv_total - dv0), 128'd50);
        check("t6_busy_in_recv", 128'(busy), 128'd1);
        respond(3);
        check("t6_partial_slot0", 128'(scores[6:0]), 128'd1);
        rst_n = 1'b0;
        #1;
        check("t6_rst_outputs", {busy, done, timeout, pad_err, tx_dv, tx_byte}, 128'd0);
        check("t6_rst_scores_best", {scores, best_class, best_score}, 128'd0);
        step();
        step();
        rst_n = 1'b1;
        step();

        // Test 7: clean run after reset
        full_run("t7", 4'd9, 7'd10, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
